// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce block family.
package debounce_pkg;

  typedef enum logic {
    DB_MODE_LOCKOUT,
    DB_MODE_SYMMETRIC
  } mode_e;

  localparam int DB_DEFAULT_DELAY = 50;
  localparam int DB_DEFAULT_SYNC  = 2;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, window counter, mode logic and edge detect.
//
// Lockout mode phases are encoded directly in cnt:
//   phase | meaning
//   IDLE  | cnt == 0, output low, waiting for s to go high
//   HOLD  | 0 < cnt < DELAY_CYCLES, output high, input ignored
//   DONE  | cnt == DELAY_CYCLES, output high until s drops
//
// Symmetric mode keeps its own level register; cnt counts consecutive
// cycles where the synchronised input disagrees with that level.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int    DELAY_CYCLES = DB_DEFAULT_DELAY,
  parameter int    SYNC_STAGES  = DB_DEFAULT_SYNC,
  parameter mode_e MODE         = DB_MODE_LOCKOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic bouncy,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DELAY_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  if (DELAY_CYCLES < 2) begin : g_bad_delay
    $error("debounce_channel: DELAY_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_channel: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic                   stable_d;

  // Plain flop chain on the raw input; nothing between stages.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bouncy};
  end

  assign s = sync_q[SYNC_STAGES-1];

  if (MODE == DB_MODE_LOCKOUT) begin : g_lockout
    localparam logic [CW-1:0] CNT_MAX = CW'(DELAY_CYCLES);

    // Trigger on the first high sample, run out the hold window, then
    // saturate until the input is seen low.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (cnt == '0) begin
        if (s) cnt <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end else if (!s) begin
        cnt <= '0;
      end
    end

    assign stable = (cnt != '0);
  end else begin : g_symmetric
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_CYCLES - 1);
    logic level_q;

    // Accept a new level only after a full window of disagreement;
    // any agreeing sample throws the partial count away.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt     <= '0;
        level_q <= 1'b0;
      end else if (s == level_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level_q <= s;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end

    assign stable = level_q;
  end

  // Delayed copy for edge detection; cleared with everything else so a
  // reset never produces a fall pulse.
  always_ff @(posedge clk) begin
    if (rst) stable_d <= 1'b0;
    else     stable_d <= stable;
  end

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

endmodule

// File: rtl/debounce_multi.sv
// Array of independent debounced inputs sharing one clock and reset.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int    CHANNELS     = 4,
  parameter int    DELAY_CYCLES = DB_DEFAULT_DELAY,
  parameter int    SYNC_STAGES  = DB_DEFAULT_SYNC,
  parameter mode_e MODE         = DB_MODE_LOCKOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] bouncy,
  output logic [CHANNELS-1:0] stable,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_multi: CHANNELS must be >= 1");
  end

  // One self-contained debouncer per bit; no shared state between channels.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DELAY_CYCLES (DELAY_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .MODE         (MODE)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .bouncy (bouncy[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: both modes side by side on the same inputs,
// checked every cycle against a time-indexed reference model.
module tb_debounce_multi;
  import debounce_pkg::*;

  localparam int CH   = 4;
  localparam int DLY  = 8;
  localparam int SYN  = 2;
  localparam int MAXE = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] bouncy = 4'hF;
  logic [CH-1:0] lk_stable, lk_rise, lk_fall;
  logic [CH-1:0] sy_stable, sy_rise, sy_fall;

  always #5 clk = ~clk;

  debounce_multi #(.CHANNELS(CH), .DELAY_CYCLES(DLY), .SYNC_STAGES(SYN),
                   .MODE(DB_MODE_LOCKOUT)) u_lock (
    .clk(clk), .rst(rst), .bouncy(bouncy),
    .stable(lk_stable), .rise(lk_rise), .fall(lk_fall)
  );

  debounce_multi #(.CHANNELS(CH), .DELAY_CYCLES(DLY), .SYNC_STAGES(SYN),
                   .MODE(DB_MODE_SYMMETRIC)) u_sym (
    .clk(clk), .rst(rst), .bouncy(bouncy),
    .stable(sy_stable), .rise(sy_rise), .fall(sy_fall)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw inputs are logged per clock edge; the synchronised
  // value seen before edge e is the raw value from SYN edges earlier, unless
  // a reset lies in between.
  int            n = 0;
  int            last_rst = 0;
  logic [CH-1:0] bhist [MAXE];
  logic [CH-1:0] m_lk = '0, m_lk_d = '0, m_sy = '0, m_sy_d = '0;
  int            lk_start [CH];

  function automatic logic s_at(input int e, input int ch);
    if (e - SYN <= last_rst) return 1'b0;
    return bhist[e - SYN][ch];
  endfunction

  // Symmetric rule: the level flips once the last DLY samples since reset
  // all disagree with it.
  function automatic logic sym_flip(input int e, input int ch, input logic lvl);
    if (e - DLY + 1 <= last_rst) return 1'b0;
    for (int k = 0; k < DLY; k++)
      if (s_at(e - k, ch) == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [CH-1:0] old_lk, old_sy;
    logic sp;
    n++;
    bhist[n] = bouncy;
    old_lk = m_lk;
    old_sy = m_sy;
    if (rst) begin
      m_lk = '0; m_lk_d = '0; m_sy = '0; m_sy_d = '0;
      last_rst = n;
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        sp = s_at(n, ch);
        if (!old_lk[ch]) begin
          if (sp) begin
            m_lk[ch] = 1'b1;
            lk_start[ch] = n;
          end
        end else if ((n - lk_start[ch] >= DLY) && !sp) begin
          m_lk[ch] = 1'b0;
        end
        if (sym_flip(n, ch, old_sy[ch])) m_sy[ch] = ~old_sy[ch];
      end
      m_lk_d = old_lk;
      m_sy_d = old_sy;
    end
  endtask

  task automatic cycle(input logic [CH-1:0] b, input logic r);
    bouncy = b;
    rst    = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("lk_stable", lk_stable, m_lk);
    check("lk_rise",   lk_rise,   m_lk & ~m_lk_d);
    check("lk_fall",   lk_fall,   ~m_lk & m_lk_d);
    check("sy_stable", sy_stable, m_sy);
    check("sy_rise",   sy_rise,   m_sy & ~m_sy_d);
    check("sy_fall",   sy_fall,   ~m_sy & m_sy_d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_a, cnt_b;
    int hold [CH];
    logic [CH-1:0] b;

    // Reset held with all inputs high, then first cycle after release.
    for (int k = 0; k < 5; k++) begin
      cycle(4'hF, 1'b1);
      check("rst_outputs", lk_stable | lk_rise | lk_fall | sy_stable | sy_rise | sy_fall, 4'h0);
    end
    cycle(4'hF, 1'b0);
    check("post_rst_outputs", lk_stable | lk_rise | lk_fall | sy_stable | sy_rise | sy_fall, 4'h0);
    for (int k = 0; k < 20; k++) cycle(4'h0, 1'b0);

    // Lockout: two-cycle pulse on channel 0.
    for (int k = 1; k <= 16; k++) begin
      cycle((k <= 2) ? 4'h1 : 4'h0, 1'b0);
      if (k == 2)  check("lk_pre_rise",   4'(lk_stable[0]), 4'h0);
      if (k == 3)  check("lk_rise_edge3", 4'(lk_rise[0] & lk_stable[0]), 4'h1);
      if (k == 10) check("lk_hold_edge10", 4'(lk_stable[0]), 4'h1);
      if (k == 11) check("lk_fall_edge11", 4'(lk_fall[0] & ~lk_stable[0]), 4'h1);
    end

    // Lockout saturation and release.
    cnt_a = 0;
    for (int k = 0; k < 100; k++) begin
      cycle(4'h1, 1'b0);
      cnt_a += int'(lk_rise[0]) + int'(lk_fall[0]);
    end
    check("sat_pulses", 4'(cnt_a), 4'h1);
    for (int k = 1; k <= 15; k++) begin
      cycle(4'h0, 1'b0);
      if (k == 2) check("sat_rel_edge2", 4'(lk_stable[0]), 4'h1);
      if (k == 3) check("sat_rel_edge3", 4'(lk_stable[0]), 4'h0);
    end

    // Symmetric: 7-cycle glitch rejected, 20-cycle level accepted.
    cnt_a = 0;
    for (int k = 0; k < 22; k++) begin
      cycle((k < 7) ? 4'h2 : 4'h0, 1'b0);
      cnt_a += int'(sy_rise[1]) + int'(sy_fall[1]) + int'(sy_stable[1]);
    end
    check("sym_glitch", 4'(cnt_a), 4'h0);
    cnt_b = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle((k <= 20) ? 4'h2 : 4'h0, 1'b0);
      if (k <= 20) cnt_b += int'(sy_rise[1]);
      if (k == 9)  check("sym_edge9",  4'(sy_stable[1]), 4'h0);
      if (k == 10) check("sym_edge10", 4'(sy_stable[1] & sy_rise[1]), 4'h1);
    end
    check("sym_one_rise", 4'(cnt_b), 4'h1);

    // Independence: channels 2 and 3 with offset rises and a shared fall.
    for (int k = 0; k < 45; k++) begin
      b = '0;
      b[2] = (k >= 3  && k < 20);
      b[3] = (k >= 10 && k < 20) || (k >= 25 && k < 29);
      cycle(b, 1'b0);
    end
    for (int k = 0; k < 15; k++) cycle(4'h0, 1'b0);

    // Reset in the middle of a lockout hold, then normal re-trigger.
    for (int k = 1; k <= 30; k++) begin
      cycle((k <= 20) ? 4'h1 : 4'h0, k == 7);
      if (k == 6)  check("mid_pre_rst",  4'(lk_stable[0]), 4'h1);
      if (k == 7)  check("mid_rst",      4'(lk_stable[0] | lk_fall[0]), 4'h0);
      if (k == 10) check("mid_retrigger", 4'(lk_rise[0]), 4'h1);
    end

    // Randomised hold lengths around the window, occasional reset.
    for (int ch = 0; ch < CH; ch++) hold[ch] = 0;
    b = '0;
    for (int k = 0; k < 2000; k++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if (hold[ch] == 0) begin
          b[ch] = 1'($urandom_range(0, 1));
          hold[ch] = int'($urandom_range(1, 25));
        end
        hold[ch]--;
      end
      cycle(b, $urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
